// File: rtl/controller_fsm_if.sv
`timescale 1ns/1ps
// Control bundle between the instruction sequencer and the CPU datapath.
// The sequencer side is the master: it reads the IR fields and drives every load/select.
interface controller_fsm_if;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w;
   logic [2:0] nsel;
   logic       loada;
   logic       loadb;
   logic       loadc;
   logic       loads;
   logic       asel;
   logic       bsel;
   logic [1:0] vsel;
   logic       write;
   logic       load_pc;
   logic       reset_pc;
   logic       addr_sel;
   logic [1:0] mem_cmd;
   logic       load_ir;
   logic       load_addr;

   modport master (
      input  s, opcode, op,
      output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel,
             write, load_pc, reset_pc, addr_sel, mem_cmd, load_ir, load_addr
   );

   modport slave (
      output s, opcode, op,
      input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel,
             write, load_pc, reset_pc, addr_sel, mem_cmd, load_ir, load_addr
   );
endinterface

// File: rtl/controller_fsm.sv
`timescale 1ns/1ps
// Moore sequencer for the simple CPU: fetch, decode, ALU, load/store and halt states.
// Outputs are registered from the next state so they always match the current state.
module controller_fsm (
   input  logic             clk,
   input  logic             reset,
   controller_fsm_if.master bus
);

   typedef enum logic [4:0] {
      GETA        = 5'b00001,
      GETB        = 5'b00010,
      DECODE      = 5'b00011,
      ADD         = 5'b00100,
      CMP         = 5'b00101,
      AND         = 5'b00110,
      MVN         = 5'b00111,
      WRITEREG    = 5'b01000,
      WRITEIMM    = 5'b01001,
      MOV         = 5'b01010,
      RST         = 5'b01011,
      IF1         = 5'b01100,
      IF2         = 5'b01101,
      UPDATEPC    = 5'b01110,
      ADDLDR      = 5'b01111,
      READLDR     = 5'b10000,
      ADDSTR      = 5'b10001,
      GETRD       = 5'b10011,
      OUTRD       = 5'b10100,
      GETEMPTYADD = 5'b10101,
      WRITELDR    = 5'b10110,
      STRWRITE    = 5'b10111,
      HALT        = 5'b11000
   } state_t;

   localparam logic [2:0] RN     = 3'b001;
   localparam logic [2:0] RD     = 3'b010;
   localparam logic [2:0] RM     = 3'b100;
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef struct packed {
      logic       w;
      logic [2:0] nsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] vsel;
      logic       write;
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic [1:0] mem_cmd;
      logic       load_ir;
      logic       load_addr;
   } ctl_t;

   state_t state;
   state_t state_next;
   ctl_t   ctl;
   logic   unused_s;

   // Only DECODE, GETA, GETB and GETEMPTYADD look at the IR; everything else is a fixed chain.
   function automatic state_t next_state(state_t st, logic [2:0] opcode, logic [1:0] op);
      state_t nx;
      nx = IF1;
      case (st)
         RST:      nx = IF1;
         IF1:      nx = IF2;
         IF2:      nx = UPDATEPC;
         UPDATEPC: nx = DECODE;
         DECODE: begin
            casez ({opcode, op})
               5'b110_10: nx = WRITEIMM;
               5'b110_00: nx = GETB;
               5'b101_??: nx = GETB;
               5'b011_00: nx = GETA;
               5'b100_00: nx = GETA;
               5'b111_??: nx = HALT;
               default:   nx = IF1;
            endcase
         end
         GETB: begin
            if (opcode == 3'b110 && op == 2'b00)      nx = MOV;
            else if (opcode == 3'b101 && op == 2'b11) nx = MVN;
            else if (opcode == 3'b101)                nx = GETA;
            else                                      nx = IF1;
         end
         GETA: begin
            casez ({opcode, op})
               5'b101_00: nx = ADD;
               5'b101_01: nx = CMP;
               5'b101_10: nx = AND;
               5'b011_??: nx = ADDLDR;
               5'b100_??: nx = ADDSTR;
               default:   nx = IF1;
            endcase
         end
         ADD, AND, MOV, MVN: nx = WRITEREG;
         CMP, WRITEREG, WRITEIMM: nx = IF1;
         ADDLDR, ADDSTR: nx = GETEMPTYADD;
         GETEMPTYADD: nx = (opcode == 3'b011) ? READLDR : GETRD;
         READLDR:  nx = WRITELDR;
         WRITELDR: nx = IF1;
         GETRD:    nx = OUTRD;
         OUTRD:    nx = STRWRITE;
         STRWRITE: nx = IF1;
         HALT:     nx = HALT;
         default:  nx = RST;
      endcase
      return nx;
   endfunction

   function automatic ctl_t decode_ctl(state_t st);
      ctl_t c;
      c         = '0;
      c.nsel    = 3'b000;
      c.mem_cmd = MNONE;
      case (st)
         RST:      begin c.w = 1'b1; c.reset_pc = 1'b1; c.load_pc = 1'b1; end
         IF1:      begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
         IF2:      begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
         UPDATEPC: c.load_pc = 1'b1;
         GETA:     begin c.nsel = RN; c.loada = 1'b1; end
         GETB:     begin c.nsel = RM; c.loadb = 1'b1; end
         ADD, AND: c.loadc = 1'b1;
         MOV, MVN: begin c.asel = 1'b1; c.loadc = 1'b1; end
         CMP:      c.loads = 1'b1;
         WRITEREG: begin c.nsel = RD; c.vsel = 2'b00; c.write = 1'b1; end
         WRITEIMM: begin c.nsel = RN; c.vsel = 2'b10; c.write = 1'b1; end
         ADDLDR, ADDSTR: begin c.bsel = 1'b1; c.loadc = 1'b1; end
         GETEMPTYADD: c.load_addr = 1'b1;
         READLDR:  c.mem_cmd = MREAD;
         WRITELDR: begin c.mem_cmd = MREAD; c.nsel = RD; c.vsel = 2'b01; c.write = 1'b1; end
         GETRD:    begin c.nsel = RD; c.loadb = 1'b1; end
         OUTRD:    begin c.asel = 1'b1; c.loadc = 1'b1; end
         STRWRITE: c.mem_cmd = MWRITE;
         HALT:     c.w = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   assign state_next = next_state(state, bus.opcode, bus.op);
   // The legacy start input is kept on the bus but never steers the sequence.
   assign unused_s   = bus.s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RST;
         ctl   <= decode_ctl(RST);
      end else begin
         state <= state_next;
         ctl   <= decode_ctl(state_next);
      end
   end

   assign bus.w         = ctl.w;
   assign bus.nsel      = ctl.nsel;
   assign bus.loada     = ctl.loada;
   assign bus.loadb     = ctl.loadb;
   assign bus.loadc     = ctl.loadc;
   assign bus.loads     = ctl.loads;
   assign bus.asel      = ctl.asel;
   assign bus.bsel      = ctl.bsel;
   assign bus.vsel      = ctl.vsel;
   assign bus.write     = ctl.write;
   assign bus.load_pc   = ctl.load_pc;
   assign bus.reset_pc  = ctl.reset_pc;
   assign bus.addr_sel  = ctl.addr_sel;
   assign bus.mem_cmd   = ctl.mem_cmd;
   assign bus.load_ir   = ctl.load_ir;
   assign bus.load_addr = ctl.load_addr;

endmodule

// File: tb/tb_controller_fsm.sv
`timescale 1ns/1ps
// Directed bench for controller_fsm: per-instruction state/output tables plus
// hand-written reset, halt and operand-immunity sequences.
module tb_controller_fsm;

   localparam logic [4:0] S_GETA = 5'b00001, S_GETB = 5'b00010, S_DECODE = 5'b00011;
   localparam logic [4:0] S_ADD = 5'b00100, S_CMP = 5'b00101, S_AND = 5'b00110, S_MVN = 5'b00111;
   localparam logic [4:0] S_WRITEREG = 5'b01000, S_WRITEIMM = 5'b01001, S_MOV = 5'b01010;
   localparam logic [4:0] S_RST = 5'b01011, S_IF1 = 5'b01100, S_IF2 = 5'b01101, S_UPDATEPC = 5'b01110;
   localparam logic [4:0] S_ADDLDR = 5'b01111, S_READLDR = 5'b10000, S_ADDSTR = 5'b10001;
   localparam logic [4:0] S_GETRD = 5'b10011, S_OUTRD = 5'b10100, S_GETEMPTYADD = 5'b10101;
   localparam logic [4:0] S_WRITELDR = 5'b10110, S_STRWRITE = 5'b10111, S_HALT = 5'b11000;

   typedef struct {
      string      name;
      logic [2:0] opcode;
      logic [1:0] op;
      int         n;
      logic [4:0] seq [8];
   } vec_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   vec_t vecs [11];

   controller_fsm_if bus ();

   controller_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word per state, field order:
   // w nsel | loada loadb loadc loads asel bsel | vsel | write load_pc reset_pc addr_sel | mem_cmd | load_ir load_addr
   function automatic logic [19:0] exp_ctl(logic [4:0] st);
      case (st)
         S_RST:         return 20'b1_000_000000_00_0110_00_00;
         S_IF1:         return 20'b0_000_000000_00_0001_01_00;
         S_IF2:         return 20'b0_000_000000_00_0001_01_10;
         S_UPDATEPC:    return 20'b0_000_000000_00_0100_00_00;
         S_GETA:        return 20'b0_001_100000_00_0000_00_00;
         S_GETB:        return 20'b0_100_010000_00_0000_00_00;
         S_ADD, S_AND:  return 20'b0_000_001000_00_0000_00_00;
         S_MOV, S_MVN:  return 20'b0_000_001010_00_0000_00_00;
         S_CMP:         return 20'b0_000_000100_00_0000_00_00;
         S_WRITEREG:    return 20'b0_010_000000_00_1000_00_00;
         S_WRITEIMM:    return 20'b0_001_000000_10_1000_00_00;
         S_ADDLDR, S_ADDSTR: return 20'b0_000_001001_00_0000_00_00;
         S_GETEMPTYADD: return 20'b0_000_000000_00_0000_00_01;
         S_READLDR:     return 20'b0_000_000000_00_0000_01_00;
         S_WRITELDR:    return 20'b0_010_000000_01_1000_01_00;
         S_GETRD:       return 20'b0_010_010000_00_0000_00_00;
         S_OUTRD:       return 20'b0_000_001010_00_0000_00_00;
         S_STRWRITE:    return 20'b0_000_000000_00_0000_10_00;
         S_HALT:        return 20'b1_000_000000_00_0000_00_00;
         default:       return 20'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [4:0] exp_st);
      logic [19:0] act;
      logic [19:0] exp;
      logic [4:0]  st;
      st  = dut.state;
      act = {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel,
             bus.vsel, bus.write, bus.load_pc, bus.reset_pc, bus.addr_sel, bus.mem_cmd,
             bus.load_ir, bus.load_addr};
      exp = exp_ctl(exp_st);
      total++;
      if (st !== exp_st) begin
         bad++;
         $display("[TB] FAIL %s state: got %b expected %b", name, st, exp_st);
      end
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp);
      end
   endtask

   // From IF1: load the IR fields and walk through fetch to DECODE.
   task automatic apply_stimulus(input string name, input logic [2:0] opcode, input logic [1:0] op);
      bus.opcode = opcode;
      bus.op     = op;
      bus.s      = 1'($urandom_range(0, 1));
      tick(); check_output({name, "_if2"}, S_IF2);
      tick(); check_output({name, "_updatepc"}, S_UPDATEPC);
      tick(); check_output({name, "_decode"}, S_DECODE);
   endtask

   initial begin
      total = 0;
      bad   = 0;

      vecs[0]  = '{"add",   3'b101, 2'b00, 5, '{S_GETB, S_GETA, S_ADD, S_WRITEREG, S_IF1, 5'd0, 5'd0, 5'd0}};
      vecs[1]  = '{"cmp",   3'b101, 2'b01, 4, '{S_GETB, S_GETA, S_CMP, S_IF1, 5'd0, 5'd0, 5'd0, 5'd0}};
      vecs[2]  = '{"and",   3'b101, 2'b10, 5, '{S_GETB, S_GETA, S_AND, S_WRITEREG, S_IF1, 5'd0, 5'd0, 5'd0}};
      vecs[3]  = '{"mvn",   3'b101, 2'b11, 4, '{S_GETB, S_MVN, S_WRITEREG, S_IF1, 5'd0, 5'd0, 5'd0, 5'd0}};
      vecs[4]  = '{"mov",   3'b110, 2'b00, 4, '{S_GETB, S_MOV, S_WRITEREG, S_IF1, 5'd0, 5'd0, 5'd0, 5'd0}};
      vecs[5]  = '{"movimm",3'b110, 2'b10, 2, '{S_WRITEIMM, S_IF1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
      vecs[6]  = '{"ldr",   3'b011, 2'b00, 6, '{S_GETA, S_ADDLDR, S_GETEMPTYADD, S_READLDR, S_WRITELDR, S_IF1, 5'd0, 5'd0}};
      vecs[7]  = '{"str",   3'b100, 2'b00, 7, '{S_GETA, S_ADDSTR, S_GETEMPTYADD, S_GETRD, S_OUTRD, S_STRWRITE, S_IF1, 5'd0}};
      vecs[8]  = '{"nop000",3'b000, 2'b00, 1, '{S_IF1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
      vecs[9]  = '{"nop110",3'b110, 2'b01, 1, '{S_IF1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
      vecs[10] = '{"nop011",3'b011, 2'b01, 1, '{S_IF1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};

      reset      = 1'b1;
      bus.s      = 1'b0;
      bus.opcode = 3'b000;
      bus.op     = 2'b00;

      #3 reset = 1'b0;
      #1 check_output("reset_async", S_RST);
      tick(); check_output("reset_hold1", S_RST);
      tick(); check_output("reset_hold2", S_RST);
      reset = 1'b1;
      tick(); check_output("release_if1", S_IF1);

      foreach (vecs[v]) begin
         apply_stimulus(vecs[v].name, vecs[v].opcode, vecs[v].op);
         for (int i = 0; i < vecs[v].n; i++) begin
            tick();
            check_output($sformatf("%s_step%0d", vecs[v].name, i), vecs[v].seq[i]);
         end
      end

      // IR changes outside the decision states must not disturb the sequence.
      apply_stimulus("immune", 3'b101, 2'b00);
      tick(); check_output("immune_getb", S_GETB);
      tick(); check_output("immune_geta", S_GETA);
      tick(); check_output("immune_add", S_ADD);
      bus.opcode = 3'b111;
      bus.op     = 2'b11;
      tick(); check_output("immune_writereg", S_WRITEREG);
      tick(); check_output("immune_if1", S_IF1);

      // HALT sticks regardless of the IR until reset.
      apply_stimulus("halt", 3'b111, 2'b01);
      tick(); check_output("halt_enter", S_HALT);
      bus.opcode = 3'b000;
      bus.op     = 2'b00;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_output($sformatf("halt_hold%0d", i), S_HALT);
      end
      #2 reset = 1'b0;
      #1 check_output("halt_reset", S_RST);
      tick(); check_output("halt_reset_hold", S_RST);
      reset = 1'b1;
      tick(); check_output("halt_release_if1", S_IF1);

      // Asynchronous reset in the middle of an ADD.
      apply_stimulus("midreset", 3'b101, 2'b00);
      tick(); check_output("midreset_getb", S_GETB);
      tick(); check_output("midreset_geta", S_GETA);
      tick(); check_output("midreset_add", S_ADD);
      #2 reset = 1'b0;
      #1 check_output("midreset_async", S_RST);
      tick(); check_output("midreset_hold", S_RST);
      reset = 1'b1;
      tick(); check_output("midreset_if1", S_IF1);
      tick(); check_output("midreset_if2", S_IF2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controller_fsm.md
CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 SHALL define localparams (5-bit): RST 01011, IF1 01100, IF2 01101, UPDATEPC 01110, DECODE 00011; meaning: fetch/decode states.
REQ-002 SHALL define localparams: GETA 00001, GETB 00010, ADD 00100, CMP 00101, AND 00110, MVN 00111, MOV 01010; meaning: ALU-path states.
REQ-003 SHALL define localparams: WRITEREG 01000, WRITEIMM 01001, ADDLDR 01111, READLDR 10000, ADDSTR 10001, GETRD 10011, OUTRD 10100, GETEMPTYADD 10101; meaning: writeback and memory states.
REQ-004 SHALL define localparams: WRITELDR 10110, STRWRITE 10111, HALT 11000; meaning: added memory/halt states. Also nsel RN 001, RD 010, RM 100; mem_cmd MNONE 00, MREAD 01, MWRITE 10.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  reset is asynchronous and active-low.
REQ-007 s  input  1  legacy start; no effect on transitions.
REQ-008 opcode  input  3  instruction opcode from IR, held stable during execution.
REQ-009 op  input  2  instruction op field from IR.
REQ-010 w  output  1  waiting flag; 1 in RST and HALT only.
REQ-011 nsel  output  3  one-hot register select (RN/RD/RM), 000 when unused.
REQ-012 loada  output  1  load datapath A register.
REQ-013 loadb  output  1  load datapath B register.
REQ-014 loadc  output  1  load datapath C register.
REQ-015 loads  output  1  load status flags.
REQ-016 asel  output  1  1 = ALU A input forced to zero.
REQ-017 bsel  output  1  1 = ALU B input is sximm5.
REQ-018 vsel  output  2  writeback source: 00 C, 01 mdata, 10 sximm8, 11 PC.
REQ-019 write  output  1  register file write enable.
REQ-020 load_pc  output  1  PC load enable.
REQ-021 reset_pc  output  1  1 = next PC is zero.
REQ-022 addr_sel  output  1  1 = memory address from PC, 0 = from address register.
REQ-023 mem_cmd  output  2  memory command MNONE/MREAD/MWRITE.
REQ-024 load_ir  output  1  instruction register load.
REQ-025 load_addr  output  1  data address register load.

Function
REQ-026 SHALL hold a 5-bit register named state using the encodings above; all outputs Moore, decoded from state only; any output not listed for a state is 0 (nsel 000, vsel 00, mem_cmd MNONE).
REQ-027 Fetch: RST(reset_pc=1, load_pc=1, w=1) -> IF1(addr_sel=1, MREAD) -> IF2(addr_sel=1, MREAD, load_ir=1) -> UPDATEPC(load_pc=1) -> DECODE, one state per clock, unconditional.
REQ-028 DECODE by {opcode,op}: 110/10 -> WRITEIMM; 110/00 -> GETB; 101/00,01,10,11 -> GETB; 011/00 -> GETA; 100/00 -> GETA; 111/xx -> HALT; any other -> IF1 (NOP).
REQ-029 GETB (nsel=RM, loadb=1): 110/00 -> MOV; 101/11 -> MVN; other 101 -> GETA.
REQ-030 GETA (nsel=RN, loada=1): 101/00 -> ADD; 101/01 -> CMP; 101/10 -> AND; 011 -> ADDLDR; 100 -> ADDSTR.
REQ-031 ADD, AND (loadc=1); MOV, MVN (asel=1, loadc=1); all -> WRITEREG; CMP (loads=1) -> IF1.
REQ-032 WRITEREG (nsel=RD, vsel=00, write=1) -> IF1; WRITEIMM (nsel=RN, vsel=10, write=1) -> IF1.
REQ-033 ADDLDR and ADDSTR (bsel=1, loadc=1) -> GETEMPTYADD (load_addr=1); then opcode 011 -> READLDR, else -> GETRD.
REQ-034 LDR: READLDR (addr_sel=0, MREAD) -> WRITELDR (addr_sel=0, MREAD, nsel=RD, vsel=01, write=1) -> IF1.
REQ-035 STR: GETRD (nsel=RD, loadb=1) -> OUTRD (asel=1, loadc=1) -> STRWRITE (addr_sel=0, MWRITE) -> IF1.
REQ-036 HALT (w=1) SHALL remain until reset; opcode/op changes outside DECODE, GETA, GETB, GETEMPTYADD SHALL not alter transitions.

Reset
REQ-037 reset low SHALL force state=RST immediately, without a clock edge, from any state including mid-instruction; while low, state stays RST; first rising edge after release -> IF1.

Verification
REQ-038 Pulse reset low -> state 01011, reset_pc=1, load_pc=1, w=1; release -> 01100, 01101, 01110, 00011 on four successive edges.
REQ-039 At DECODE opcode=101 op=00 -> GETB(00010, nsel=100), GETA(00001, nsel=001), ADD(00100), WRITEREG(01000, write=1), IF1.
REQ-040 opcode=110 op=10 -> WRITEIMM(01001, nsel=001, vsel=10, write=1) -> IF1; opcode=101 op=01 -> GETB, GETA, CMP(loads=1), IF1.
REQ-041 opcode=011 op=00 -> GETA, ADDLDR(bsel=1), GETEMPTYADD(load_addr=1), READLDR(mem_cmd=01, addr_sel=0), WRITELDR(vsel=01), IF1.
REQ-042 opcode=100 op=00 -> GETA, ADDSTR, GETEMPTYADD, GETRD, OUTRD(asel=1), STRWRITE(mem_cmd=10), IF1; opcode=111 -> HALT held 10 clocks.
REQ-043 reset low asynchronously while in ADD -> state RST before next edge; after release, fetch sequence restarts at IF1.
